// File: rtl/i2c_target.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : i2c_target                                                  |
// | Purpose  : Oversampled I2C target on one 7-bit address giving an       |
// |            external master pointer-based access to a fabric register   |
// |            file. Open-drain SDA via o_sda_oe, no clock stretching.     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h3C,
  parameter int         FILTER_LEN  = 4,
  parameter int         HOLD_CYC    = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_we,
  output logic       o_reg_re,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy
);

  localparam int                  c_HOLD_W    = $clog2(HOLD_CYC + 1);
  localparam logic [3:0]          c_FLT_MAX   = 4'(FILTER_LEN - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_INIT = c_HOLD_W'(HOLD_CYC);
  localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  state_t                r_state;
  logic                  r_scl_meta, r_scl_sync, r_sda_meta, r_sda_sync;
  logic                  r_scl_flt, r_sda_flt, r_scl_d, r_sda_d;
  logic [3:0]            r_scl_cnt, r_sda_cnt;
  logic [3:0]            r_bit;
  logic [7:0]            r_shift;
  logic                  r_rw;
  logic                  r_load;
  logic                  r_oe_pend;
  logic [c_HOLD_W-1:0]   r_hold;

  logic                  w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]            w_byte;

  assign w_scl_rise = r_scl_flt & ~r_scl_d;
  assign w_scl_fall = ~r_scl_flt & r_scl_d;
  assign w_start    = r_scl_flt & r_scl_d & r_sda_d & ~r_sda_flt;
  assign w_stop     = r_scl_flt & r_scl_d & ~r_sda_d & r_sda_flt;
  assign w_byte     = {r_shift[6:0], r_sda_flt};

  // Two-flop synchronisers plus one-cycle-delayed filtered copies for edge detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_meta <= i_scl;
      r_scl_sync <= r_scl_meta;
      r_sda_meta <= i_sda;
      r_sda_sync <= r_sda_meta;
      r_scl_d    <= r_scl_flt;
      r_sda_d    <= r_sda_flt;
    end
  end

  // Glitch filters: a level change needs FILTER_LEN consecutive differing samples
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_cnt <= 4'd0;
      r_scl_flt <= 1'b1;
      r_sda_cnt <= 4'd0;
      r_sda_flt <= 1'b1;
    end else begin
      if (r_scl_sync == r_scl_flt) begin
        r_scl_cnt <= 4'd0;
      end else if (r_scl_cnt == c_FLT_MAX) begin
        r_scl_flt <= r_scl_sync;
        r_scl_cnt <= 4'd0;
      end else begin
        r_scl_cnt <= r_scl_cnt + 4'd1;
      end
      if (r_sda_sync == r_sda_flt) begin
        r_sda_cnt <= 4'd0;
      end else if (r_sda_cnt == c_FLT_MAX) begin
        r_sda_flt <= r_sda_sync;
        r_sda_cnt <= 4'd0;
      end else begin
        r_sda_cnt <= r_sda_cnt + 4'd1;
      end
    end
  end

  // Protocol FSM; SDA drive is staged in r_oe_pend and applied HOLD_CYC after each SCL fall
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_bit       <= 4'd0;
      r_shift     <= 8'h00;
      r_rw        <= 1'b0;
      r_load      <= 1'b0;
      r_oe_pend   <= 1'b0;
      r_hold      <= '0;
      o_sda_oe    <= 1'b0;
      o_reg_addr  <= 8'h00;
      o_reg_wdata <= 8'h00;
      o_reg_we    <= 1'b0;
      o_reg_re    <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_reg_we <= 1'b0;
      o_reg_re <= 1'b0;
      // read data is valid the cycle after the request, so capture one cycle later
      r_load   <= o_reg_re;

      if (r_hold != '0) begin
        r_hold <= r_hold - c_HOLD_ONE;
        if (r_hold == c_HOLD_ONE) o_sda_oe <= r_oe_pend;
      end

      // r_shift[7] holds the next bit to send once the MSB is staged directly
      if (r_load && r_state == S_RDATA) begin
        r_shift   <= {i_reg_rdata[6:0], 1'b0};
        r_oe_pend <= ~i_reg_rdata[7];
      end

      if (w_start || w_stop) begin
        // bus conditions abort whatever byte is in flight and release SDA at once
        o_sda_oe  <= 1'b0;
        r_oe_pend <= 1'b0;
        r_hold    <= '0;
        r_load    <= 1'b0;
        o_busy    <= 1'b0;
        r_bit     <= 4'd0;
        r_state   <= w_start ? S_ADDR : S_IDLE;
      end else begin
        if (w_scl_fall) r_hold <= c_HOLD_INIT;
        case (r_state)
          S_IDLE, S_IGNORE: begin
            if (w_scl_fall) r_oe_pend <= 1'b0;
          end
          S_ADDR, S_PTR, S_WDATA: begin
            if (w_scl_fall) r_oe_pend <= 1'b0;
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_bit   <= r_bit + 4'd1;
              if (r_bit == 4'd7) begin
                case (r_state)
                  S_ADDR: begin
                    if (w_byte[7:1] == TARGET_ADDR && w_byte[7:1] != 7'd0) begin
                      r_state <= S_ADDR_ACK;
                      r_rw    <= w_byte[0];
                      o_busy  <= 1'b1;
                    end else begin
                      r_state <= S_IGNORE;
                    end
                  end
                  S_PTR: begin
                    o_reg_addr <= w_byte;
                    r_state    <= S_PTR_ACK;
                  end
                  default: begin
                    o_reg_wdata <= w_byte;
                    o_reg_we    <= 1'b1;
                    r_state     <= S_WDATA_ACK;
                  end
                endcase
              end
            end
          end
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            // first fall (bit count 8) starts the ACK, second fall ends the 9th clock
            if (w_scl_fall) begin
              if (r_bit == 4'd8) begin
                r_oe_pend <= 1'b1;
                r_bit     <= 4'd0;
              end else begin
                r_oe_pend <= 1'b0;
                case (r_state)
                  S_ADDR_ACK: begin
                    if (r_rw) begin
                      o_reg_re <= 1'b1;
                      r_state  <= S_RDATA;
                    end else begin
                      r_state  <= S_PTR;
                    end
                  end
                  S_PTR_ACK: r_state <= S_WDATA;
                  default: begin
                    o_reg_addr <= o_reg_addr + 8'd1;
                    r_state    <= S_WDATA;
                  end
                endcase
              end
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              r_bit <= r_bit + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit == 4'd8) begin
                r_oe_pend <= 1'b0;
                r_state   <= S_RDATA_ACK;
              end else if (r_bit != 4'd0) begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_oe_pend <= ~r_shift[7];
              end
            end
          end
          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              o_reg_addr <= o_reg_addr + 8'd1;
              r_bit      <= 4'd0;
              if (!r_sda_flt) begin
                o_reg_re <= 1'b1;
                r_state  <= S_RDATA;
              end else begin
                o_sda_oe <= 1'b0;
                o_busy   <= 1'b0;
                r_state  <= S_IGNORE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_i2c_target                                               |
// | Purpose  : Bit-banged I2C master with register-strobe scoreboard and   |
// |            table-driven write transfers for i2c_target.                |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_i2c_target;

  localparam int Q = 20;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       oe, we, re, busy;
  logic [7:0] raddr, wdata, rdata;
  logic [7:0] rd_mem [256];

  int checks = 0;
  int errors = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;

  typedef struct packed {
    logic       is_rd;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;
  ev_t exp_q[$];

  typedef struct {
    logic [6:0] dev;
    logic [7:0] ptr;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       glitch;
    logic       exp_ack;
    logic [7:0] exp_ptr;
  } wvec_t;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~oe;

  i2c_target #(.TARGET_ADDR(7'h3C), .FILTER_LEN(4), .HOLD_CYC(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_scl      (scl_m),
    .i_sda      (sda_line),
    .o_sda_oe   (oe),
    .o_reg_addr (raddr),
    .o_reg_wdata(wdata),
    .o_reg_we   (we),
    .o_reg_re   (re),
    .i_reg_rdata(rdata),
    .o_busy     (busy)
  );

  // register file read port: data valid the cycle after the request
  always @(posedge clk) begin
    if (re) rdata <= rd_mem[raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: every write/read strobe must match the next expected event
  always @(negedge clk) begin
    ev_t got;
    ev_t want;
    if (oe) oe_cnt++;
    if (busy) busy_cnt++;
    if (rst_n && (we || re)) begin
      got = {re, raddr, (re ? 8'h00 : wdata)};
      if (we && re) check("we_re_exclusive", 32'(we & re), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got 0x%0h, expected none", got);
      end else begin
        want = exp_q.pop_front();
        check("strobe", 32'(got), 32'(want));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_xfer(input logic b, input logic glitch, output logic s);
    sda_m = b;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    s = sda_line;
    if (glitch) begin
      sda_m = ~b;
      cyc(3);
      sda_m = b;
      cyc(Q - 3);
    end else begin
      cyc(Q);
    end
    scl_m = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    sda_m = 1'b0;
    cyc(2 * Q);
    scl_m = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    cyc(Q);
    scl_m = 1'b1;
    cyc(2 * Q);
    sda_m = 1'b1;
    cyc(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic glitch, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], glitch, s);
    bit_xfer(1'b1, 1'b0, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, 1'b0, s);
      d = {d[6:0], s};
    end
    bit_xfer(~ack, 1'b0, s);
  endtask

  task automatic write_xfer(input wvec_t v);
    logic       a;
    logic [7:0] d;
    logic [7:0] pa;
    int         oe0;
    int         busy0;
    oe0   = oe_cnt;
    busy0 = busy_cnt;
    i2c_start();
    send_byte({v.dev, 1'b0}, 1'b0, a);
    check("addr_ack", 32'(a), 32'(v.exp_ack));
    check("busy_after_addr", 32'(busy), 32'(v.exp_ack));
    send_byte(v.ptr, v.glitch, a);
    check("ptr_ack", 32'(a), 32'(v.exp_ack));
    for (int i = 0; i < v.n; i++) begin
      d  = (i == 0) ? v.d0 : v.d1;
      pa = v.ptr + 8'(i);
      if (v.exp_ack) exp_q.push_back({1'b0, pa, d});
      send_byte(d, 1'b0, a);
      check("data_ack", 32'(a), 32'(v.exp_ack));
    end
    i2c_stop();
    check("busy_after_stop", 32'(busy), 32'd0);
    check("oe_seen", 32'(oe_cnt != oe0), 32'(v.exp_ack));
    check("busy_seen", 32'(busy_cnt != busy0), 32'(v.exp_ack));
    if (v.exp_ack) check("ptr_after", 32'(raddr), 32'(v.exp_ptr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    wvec_t      vec [5];
    logic       a;
    logic       s;
    logic [7:0] d;

    vec[0] = '{7'h3C, 8'h10, 2, 8'hA5, 8'h5A, 1'b0, 1'b1, 8'h12};
    vec[1] = '{7'h3D, 8'h00, 1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vec[2] = '{7'h3C, 8'hFF, 2, 8'h01, 8'h02, 1'b0, 1'b1, 8'h01};
    vec[3] = '{7'h3C, 8'h30, 1, 8'hC3, 8'h00, 1'b1, 1'b1, 8'h31};
    vec[4] = '{7'h00, 8'h55, 1, 8'h66, 8'h00, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 256; i++) rd_mem[i] = 8'(i) ^ 8'h5C;
    rd_mem[8'h20] = 8'h11;
    rd_mem[8'h21] = 8'h22;
    rd_mem[8'h50] = 8'h00;

    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    cyc(5);
    check("rst_sda_oe", 32'(oe), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_re", 32'(re), 32'd0);
    check("rst_addr", 32'(raddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cyc(10);

    for (int i = 0; i < 5; i++) write_xfer(vec[i]);

    // pointer write, repeated START, two-byte read ACK then NACK
    i2c_start();
    send_byte(8'h78, 1'b0, a);
    check("rd_wr_addr_ack", 32'(a), 32'd1);
    send_byte(8'h20, 1'b0, a);
    check("rd_ptr_ack", 32'(a), 32'd1);
    exp_q.push_back({1'b1, 8'h20, 8'h00});
    exp_q.push_back({1'b1, 8'h21, 8'h00});
    i2c_start();
    send_byte(8'h79, 1'b0, a);
    check("rd_addr_ack", 32'(a), 32'd1);
    recv_byte(1'b1, d);
    check("rd_byte0", 32'(d), 32'h11);
    recv_byte(1'b0, d);
    check("rd_byte1", 32'(d), 32'h22);
    check("rd_busy_after_nack", 32'(busy), 32'd0);
    i2c_stop();
    check("rd_ptr_after", 32'(raddr), 32'h22);

    // STOP after four data bits: no write strobe, then a normal transfer
    i2c_start();
    send_byte(8'h78, 1'b0, a);
    check("part_addr_ack", 32'(a), 32'd1);
    send_byte(8'h40, 1'b0, a);
    check("part_ptr_ack", 32'(a), 32'd1);
    bit_xfer(1'b1, 1'b0, s);
    bit_xfer(1'b0, 1'b0, s);
    bit_xfer(1'b1, 1'b0, s);
    bit_xfer(1'b0, 1'b0, s);
    i2c_stop();
    check("part_oe", 32'(oe), 32'd0);
    check("part_busy", 32'(busy), 32'd0);
    write_xfer('{7'h3C, 8'h41, 1, 8'h77, 8'h00, 1'b0, 1'b1, 8'h42});

    // reset asserted while the target drives a zero data bit
    i2c_start();
    send_byte(8'h78, 1'b0, a);
    send_byte(8'h50, 1'b0, a);
    exp_q.push_back({1'b1, 8'h50, 8'h00});
    i2c_start();
    send_byte(8'h79, 1'b0, a);
    check("rst_rd_addr_ack", 32'(a), 32'd1);
    bit_xfer(1'b1, 1'b0, s);
    bit_xfer(1'b1, 1'b0, s);
    sda_m = 1'b1;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    check("oe_before_reset", 32'(oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check("oe_in_reset", 32'(oe), 32'd0);
    check("busy_in_reset", 32'(busy), 32'd0);
    cyc(5);
    rst_n = 1'b1;
    cyc(4 * Q);
    write_xfer('{7'h3C, 8'h60, 1, 8'h9E, 8'h00, 1'b0, 1'b1, 8'h61});

    cyc(10);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
